board_store: RTL and testbench
==============================

// Module: board_store
// PURPOSE
// - Parametrised Connect-Four board memory with gravity drop, per-column heights, undo (pop top piece) and a cell-by-cell clear sweep.
// - Sits between the game controller (command/response handshake) and the win checker/renderer (random read port, status flags).
// - A sweep clears the board after reset and on clear_req. Commands are refused until the sweep finishes.
// PARAMETERS
// - ROWS       6  board height; the drop row is 0 (bottom)
// - COLS       7  board width
// - CELL_BITS  2  bits per cell; 0 = empty, any non-zero value = a player piece
// - Derived: ROW_W=$clog2(ROWS), COL_W=$clog2(COLS), H_W=$clog2(ROWS+1), N=ROWS*COLS, CNT_W=$clog2(N+1)
// PORTS
// - clk          in   1          clock
// - rst_n        in   1          asynchronous, active-low reset
// - clear_req    in   1          single-cycle request to start a clear sweep
// - ready        out  1          registered; 1 when idle and able to accept a command
// - cmd_valid    in   1          command strobe
// - cmd_op       in   1          0 = drop, 1 = undo
// - cmd_col      in   COL_W      target column
// - cmd_piece    in   CELL_BITS  piece value for a drop (ignored for undo)
// - rsp_valid    out  1          one-cycle pulse, the cycle after an accepted command
// - rsp_ok       out  1          1 = the command took effect
// - rsp_row      out  ROW_W      row that was written or emptied; 0 when rsp_ok=0
// - rd_row       in   ROW_W      read address, row
// - rd_col       in   COL_W      read address, column
// - rd_data      out  CELL_BITS  combinational read of the cell at (rd_row, rd_col)
// - col_full     out  COLS       bit c = 1 when height[c]==ROWS
// - board_full   out  1          1 when piece_count==N
// - piece_count  out  CNT_W      number of non-empty cells
// BEHAVIOUR
// - FSM states: CLEAR, IDLE. rst_n low forces CLEAR.
// - Reset values: sweep counter 0, all heights 0, piece_count 0, ready 0, rsp_valid/rsp_ok/rsp_row 0. Cells have no async reset; the sweep clears them.
// - CLEAR: clears one cell per cycle, index 0..N-1 (row = idx/COLS, col = idx%COLS).
//   - Heights and piece_count are zeroed on entry.
//   - After the cycle that clears idx N-1: go to IDLE, ready=1 on the next edge.
//   - ready is low for exactly N cycles after rst_n deasserts or after clear_req is sampled.
//   - rd_data reads 0 throughout CLEAR.
// - clear_req in IDLE: go to CLEAR. clear_req in CLEAR: restart the sweep at idx 0.
// - A command is accepted on cmd_valid && ready. The response comes one cycle later and ready stays high. Throughput is 1 command per cycle.
// - Drop succeeds when: cmd_col<COLS, cmd_piece!=0, and h=height[cmd_col] < ROWS.
//   - Effect: board[h][col]=cmd_piece, height++, piece_count++, rsp_ok=1, rsp_row=h.
// - Undo succeeds when: cmd_col<COLS and h>0.
//   - Effect: board[h-1][col]=0, height--, piece_count--, rsp_ok=1, rsp_row=h-1.
// - Any failed condition: no state change, rsp_valid=1, rsp_ok=0, rsp_row=0.
// - cmd_valid and clear_req in the same IDLE cycle: clear wins, the command is rejected (rsp_ok=0) and the sweep starts.
// - rd_row>=ROWS or rd_col>=COLS: rd_data=0.
// - rd_data of a cell written at edge k shows the new value after edge k (no bypass needed).
// - col_full, board_full and piece_count are derived from registered state and update on the same edge as the write.
// - rst_n asserted mid-sweep or mid-command: all outputs go to reset values immediately. The sweep restarts from 0 after release.
// TESTING
// - Release rst_n -> ready=0 for exactly 42 clocks (defaults), then 1; every rd_data==0; piece_count==0.
// - 7 drops, col 3, piece 1 -> rsp_ok=1 with rsp_row 0..5 for drops 1-6; 7th rsp_ok=0; col_full==7'b0001000.
// - Drop piece 2 twice into col 0, then undo col 0 -> rsp_row=1, rd(1,0)=0, rd(0,0)=2, piece_count=1. Undo on an empty column -> rsp_ok=0.
// - Fill all 42 cells -> board_full=1, piece_count=42. Pulse clear_req -> ready=0 for 42 cycles, then all cells 0 and col_full=0.
// - Drop with cmd_col=7 or cmd_piece=0 -> rsp_ok=0, no change. cmd_valid together with clear_req -> rsp_ok=0 and the sweep starts.
// - Pulse rst_n low at sweep idx 20 -> rsp/ready go to 0 asynchronously; after release, ready=0 for another full 42 cycles.

Source files
------------

// File: rtl/board_store.sv
// Connect-Four board memory: gravity drop, undo of the top piece per column,
// and a one-cell-per-cycle clear sweep that runs after reset and on request.
module board_store #(
    parameter  int ROWS      = 6,
    parameter  int COLS      = 7,
    parameter  int CELL_BITS = 2,
    localparam int ROW_W     = $clog2(ROWS),
    localparam int COL_W     = $clog2(COLS),
    localparam int H_W       = $clog2(ROWS + 1),
    localparam int N         = ROWS * COLS,
    localparam int CNT_W     = $clog2(N + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_req,
    output logic                 ready,
    input  logic                 cmd_valid,
    input  logic                 cmd_op,
    input  logic [COL_W-1:0]     cmd_col,
    input  logic [CELL_BITS-1:0] cmd_piece,
    output logic                 rsp_valid,
    output logic                 rsp_ok,
    output logic [ROW_W-1:0]     rsp_row,
    input  logic [ROW_W-1:0]     rd_row,
    input  logic [COL_W-1:0]     rd_col,
    output logic [CELL_BITS-1:0] rd_data,
    output logic [COLS-1:0]      col_full,
    output logic                 board_full,
    output logic [CNT_W-1:0]     piece_count
);

    localparam int IDX_W = $clog2(N);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 ready_q, ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_ok_q, rsp_ok_d;
    logic [ROW_W-1:0]     rsp_row_q, rsp_row_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [H_W-1:0]       height_q [COLS];
    logic [H_W-1:0]       height_d [COLS];
    logic [CELL_BITS-1:0] cells_q [N];

    logic                 wr_en;
    logic [IDX_W-1:0]     wr_idx;
    logic [CELL_BITS-1:0] wr_data;

    logic [H_W-1:0]       h_sel;
    logic [H_W-1:0]       h_m1;
    logic                 col_ok, cmd_acc, drop_ok, undo_ok;
    logic [IDX_W-1:0]     drop_idx, undo_idx;
    logic                 rd_ok;
    logic [IDX_W-1:0]     rd_idx;

    always_comb begin
        h_sel = '0;
        for (int c = 0; c < COLS; c++) begin
            if (cmd_col == COL_W'(c)) h_sel = height_q[c];
        end
    end

    assign h_m1     = h_sel - H_W'(1);
    assign col_ok   = ({1'b0, cmd_col} < (COL_W + 1)'(COLS));
    assign cmd_acc  = cmd_valid && ready_q;
    assign drop_ok  = cmd_acc && !clear_req && !cmd_op && col_ok
                      && (cmd_piece != '0) && (h_sel < H_W'(ROWS));
    assign undo_ok  = cmd_acc && !clear_req && cmd_op && col_ok && (h_sel != '0);
    assign drop_idx = IDX_W'(h_sel) * IDX_W'(COLS) + IDX_W'(cmd_col);
    assign undo_idx = IDX_W'(h_m1) * IDX_W'(COLS) + IDX_W'(cmd_col);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        rsp_ok_d    = 1'b0;
        rsp_row_d   = '0;
        cnt_d       = cnt_q;
        height_d    = height_q;
        wr_en       = 1'b0;
        wr_idx      = idx_q;
        wr_data     = '0;
        case (state_q)
            ST_CLEAR: begin
                wr_en = 1'b1;
                if (clear_req) begin
                    idx_d = '0;
                end else if (idx_q == IDX_W'(N - 1)) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_IDLE: begin
                rsp_valid_d = cmd_acc;
                if (clear_req) begin
                    // A clear in the same cycle as a command wins; the command is answered with rsp_ok=0.
                    state_d = ST_CLEAR;
                    ready_d = 1'b0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    for (int c = 0; c < COLS; c++) height_d[c] = '0;
                end else if (drop_ok) begin
                    wr_en     = 1'b1;
                    wr_idx    = drop_idx;
                    wr_data   = cmd_piece;
                    rsp_ok_d  = 1'b1;
                    rsp_row_d = ROW_W'(h_sel);
                    cnt_d     = cnt_q + CNT_W'(1);
                    for (int c = 0; c < COLS; c++) begin
                        if (cmd_col == COL_W'(c)) height_d[c] = h_sel + H_W'(1);
                    end
                end else if (undo_ok) begin
                    wr_en     = 1'b1;
                    wr_idx    = undo_idx;
                    wr_data   = '0;
                    rsp_ok_d  = 1'b1;
                    rsp_row_d = ROW_W'(h_m1);
                    cnt_d     = cnt_q - CNT_W'(1);
                    for (int c = 0; c < COLS; c++) begin
                        if (cmd_col == COL_W'(c)) height_d[c] = h_m1;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            idx_q       <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_ok_q    <= 1'b0;
            rsp_row_q   <= '0;
            cnt_q       <= '0;
            for (int c = 0; c < COLS; c++) height_q[c] <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ok_q    <= rsp_ok_d;
            rsp_row_q   <= rsp_row_d;
            cnt_q       <= cnt_d;
            height_q    <= height_d;
        end
    end

    // Cell storage has no reset; the sweep is what empties it.
    always_ff @(posedge clk) begin
        if (wr_en) cells_q[wr_idx] <= wr_data;
    end

    assign rd_ok   = (state_q == ST_IDLE)
                     && ({1'b0, rd_row} < (ROW_W + 1)'(ROWS))
                     && ({1'b0, rd_col} < (COL_W + 1)'(COLS));
    assign rd_idx  = IDX_W'(rd_row) * IDX_W'(COLS) + IDX_W'(rd_col);
    assign rd_data = rd_ok ? cells_q[rd_idx] : '0;

    for (genvar c = 0; c < COLS; c++) begin : g_full
        assign col_full[c] = (height_q[c] == H_W'(ROWS));
    end

    assign board_full  = (cnt_q == CNT_W'(N));
    assign piece_count = cnt_q;
    assign ready       = ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_ok      = rsp_ok_q;
    assign rsp_row     = rsp_row_q;

endmodule

// File: tb/tb_board_store.sv
// Bench for board_store: directed scenarios plus random command traffic,
// checked against a per-column stack model of the board.
module tb_board_store;

    localparam int ROWS = 6;
    localparam int COLS = 7;
    localparam int N    = ROWS * COLS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clear_req = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_op = 1'b0;
    logic [2:0] cmd_col = '0;
    logic [1:0] cmd_piece = '0;
    logic [2:0] rd_row = '0;
    logic [2:0] rd_col = '0;
    logic       ready, rsp_valid, rsp_ok, board_full;
    logic [2:0] rsp_row;
    logic [1:0] rd_data;
    logic [6:0] col_full;
    logic [5:0] piece_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: each column is a stack of pieces, bottom first.
    int stk [COLS][$];

    board_store dut (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_col(cmd_col), .cmd_piece(cmd_piece),
        .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_row(rsp_row),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .col_full(col_full), .board_full(board_full), .piece_count(piece_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int m_count();
        int s = 0;
        for (int c = 0; c < COLS; c++) s += stk[c].size();
        return s;
    endfunction

    function automatic int m_full();
        int v = 0;
        for (int c = 0; c < COLS; c++) if (stk[c].size() == ROWS) v |= (1 << c);
        return v;
    endfunction

    function automatic int m_cell(input int r, input int c);
        if (r >= ROWS || c >= COLS) return 0;
        if (r >= stk[c].size()) return 0;
        return stk[c][r];
    endfunction

    task automatic m_clear();
        for (int c = 0; c < COLS; c++) stk[c].delete();
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, piece_count, m_count());
        check({tag, "_colfull"}, col_full, m_full());
        check({tag, "_bfull"}, board_full, (m_count() == N) ? 1 : 0);
    endtask

    task automatic check_board(input string tag);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                rd_row = 3'(r);
                rd_col = 3'(c);
                #1;
                check(tag, rd_data, m_cell(r, c));
            end
        end
    endtask

    // Counts cycles until ready rises; rd_data must stay 0 meanwhile.
    task automatic wait_ready(input string tag);
        int cyc = 0;
        while (ready !== 1'b1 && cyc < 200) begin
            check({tag, "_rd0"}, rd_data, 0);
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_len"}, cyc, N);
    endtask

    task automatic step(input bit v, input bit op, input int col, input int piece, input bit clr);
        bit eok = 1'b0;
        int erow = 0;
        @(negedge clk);
        cmd_valid = v;
        cmd_op    = op;
        cmd_col   = 3'(col);
        cmd_piece = 2'(piece);
        clear_req = clr;
        if (clr) begin
            m_clear();
        end else if (v && col < COLS) begin
            if (!op && piece != 0 && stk[col].size() < ROWS) begin
                eok  = 1'b1;
                erow = stk[col].size();
                stk[col].push_back(piece);
            end else if (op && stk[col].size() > 0) begin
                eok  = 1'b1;
                erow = stk[col].size() - 1;
                void'(stk[col].pop_back());
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        clear_req = 1'b0;
        check("rsp_valid", rsp_valid, v);
        if (v) begin
            check("rsp_ok", rsp_ok, eok);
            check("rsp_row", rsp_row, erow);
        end
        check("ready", ready, clr ? 0 : 1);
        check_status("st");
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        m_clear();
        check("clr_ready0", ready, 0);
        check_status("clr_entry");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_clear();
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_ok", rsp_ok, 0);
        check("rst_rsp_row", rsp_row, 0);
        check("rst_count", piece_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ready("sweep_rst");
        check_board("rst_board");
        check_status("rst_st");

        // Stack seven pieces in column 3; the seventh is refused.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 3, 1, 1'b0);
        check("col3_full", col_full, 7'b0001000);

        do_clear();
        wait_ready("sweep_clr1");
        step(1'b1, 1'b0, 0, 2, 1'b0);
        step(1'b1, 1'b0, 0, 2, 1'b0);
        step(1'b1, 1'b1, 0, 0, 1'b0);
        check("undo_row", rsp_row, 1);
        rd_row = 3'd1; rd_col = 3'd0; #1;
        check("rd_1_0", rd_data, 0);
        rd_row = 3'd0; #1;
        check("rd_0_0", rd_data, 2);
        check("undo_count", piece_count, 1);
        step(1'b1, 1'b1, 1, 0, 1'b0);
        check("undo_empty_ok", rsp_ok, 0);

        // Malformed commands change nothing.
        step(1'b1, 1'b0, 7, 1, 1'b0);
        step(1'b1, 1'b0, 2, 0, 1'b0);
        step(1'b1, 1'b1, 7, 0, 1'b0);
        check_board("bad_board");

        for (int c = 0; c < COLS; c++) begin
            while (stk[c].size() < ROWS) step(1'b1, 1'b0, c, (stk[c].size() + c) % 3 + 1, 1'b0);
        end
        check("fill_bfull", board_full, 1);
        check("fill_count", piece_count, N);
        step(1'b1, 1'b0, 5, 3, 1'b0);
        check_board("full_board");

        rd_row = 3'd0; rd_col = 3'd3;
        do_clear();
        wait_ready("sweep_clr2");
        check_board("cleared_board");
        check("cleared_colfull", col_full, 0);

        // Command and clear together: clear wins.
        step(1'b1, 1'b0, 1, 1, 1'b0);
        step(1'b1, 1'b0, 1, 1, 1'b1);
        wait_ready("sweep_cmdclr");
        check_board("cmdclr_board");

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                 $urandom_range(0, 7), $urandom_range(0, 3), 1'b0);
            rd_row = 3'($urandom_range(0, 7));
            rd_col = 3'($urandom_range(0, 7));
            #1;
            check("rand_rd", rd_data, m_cell(rd_row, rd_col));
        end
        check_board("rand_board");

        // Asynchronous reset right after a response.
        while (stk[4].size() >= ROWS) step(1'b1, 1'b1, 4, 0, 1'b0);
        step(1'b1, 1'b0, 4, 1, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        m_clear();
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_rsp_ok", rsp_ok, 0);
        check("arst_ready", ready, 0);
        check_status("arst");
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("sweep_arst");

        // Reset in the middle of a sweep restarts it from the beginning.
        step(1'b1, 1'b0, 2, 3, 1'b0);
        do_clear();
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_ready", ready, 0);
        check("mid_rsp_valid", rsp_valid, 0);
        check_status("mid");
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("sweep_mid");
        check_board("mid_board");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
